// File: rtl/data_memory_pipe.sv
// rtl/data_memory_pipe.sv - word memory with self-clearing INIT phase and fixed-latency response pipe
module data_memory_pipe #(
    parameter int BUS     = 32,
    parameter int MEMSIZE = 4096,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [BUS-1:0]     req_addr,
    input  logic [BUS-1:0]     req_wdata,
    input  logic [BUS/8-1:0]   req_be,
    output logic               rsp_valid,
    output logic [BUS-1:0]     rsp_rdata,
    output logic               rsp_err
);

    localparam int OFF = $clog2(BUS / 8);
    localparam int IW  = $clog2(MEMSIZE);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]     state;
    logic [IW-1:0]  clr_idx;
    logic [BUS-1:0] mem [MEMSIZE];

    logic [BUS-1:0] word_idx;
    logic [IW-1:0]  idx;
    logic           misaligned;
    logic           out_of_range;
    logic           req_err;
    logic           accept;
    logic           wr_en;
    logic           clr_en;

    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_err;
    logic [BUS-1:0]    pipe_rdata [RD_LAT];

    always_comb begin
        word_idx     = req_addr >> OFF;
        idx          = word_idx[IW-1:0];
        misaligned   = |req_addr[OFF-1:0];
        out_of_range = word_idx >= BUS'(MEMSIZE);
        req_err      = misaligned || out_of_range;
        // reset takes priority over a request presented in the same cycle
        accept       = req_valid && (state == ST_RUN) && !rst;
        wr_en        = accept && req_we && !req_err;
        clr_en       = (state == ST_INIT) && !rst;
    end

    assign req_ready = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            clr_idx <= '0;
        end else if (state == ST_INIT) begin
            clr_idx <= clr_idx + IW'(1);
            if (clr_idx == IW'(MEMSIZE - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BUS / 8; b++) begin
                if (req_be[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // stage data is zero whenever its valid bit is clear, so outputs need no gating
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_rdata[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && req_err;
            pipe_rdata[0] <= (accept && !req_we && !req_err) ? mem[idx] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
        end
    end

    assign rsp_valid = pipe_valid[RD_LAT-1];
    assign rsp_err   = pipe_err[RD_LAT-1];
    assign rsp_rdata = pipe_rdata[RD_LAT-1];

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb/tb_data_memory_pipe.sv - directed bench for data_memory_pipe, latencies 2 and 4 side by side
module tb_data_memory_pipe;

    localparam int MEMSIZE = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        ready2, valid2, err2;
    logic [31:0] rdata2;
    logic        ready4, valid4, err4;
    logic [31:0] rdata4;

    always #5 clk = ~clk;

    data_memory_pipe #(.BUS(32), .MEMSIZE(MEMSIZE), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(valid2), .rsp_rdata(rdata2), .rsp_err(err2)
    );

    data_memory_pipe #(.BUS(32), .MEMSIZE(MEMSIZE), .RD_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready4),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(valid4), .rsp_rdata(rdata4), .rsp_err(err4)
    );

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          started = 0;
    bit          in_init = 1;
    int          init_left = 0;
    logic [31:0] mmem [MEMSIZE];
    rsp_t        q2[$];
    rsp_t        q4[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: memory is all-zero once INIT completes; responses are queued by due cycle
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                started   = 1;
                in_init   = 1;
                init_left = MEMSIZE;
                q2.delete();
                q4.delete();
                foreach (mmem[i]) mmem[i] = '0;
            end else if (started && in_init) begin
                init_left--;
                if (init_left == 0) in_init = 0;
            end else if (started && req_valid) begin
                rsp_t        r;
                logic [31:0] wi;
                wi      = req_addr / 4;
                r.err   = (req_addr % 4 != 0) || (wi >= MEMSIZE);
                r.rdata = (!req_we && !r.err) ? mmem[wi] : 32'h0;
                if (req_we && !r.err) begin
                    for (int b = 0; b < 4; b++)
                        if (req_be[b]) mmem[wi][8*b +: 8] = req_wdata[8*b +: 8];
                end
                r.due = cyc + 1;
                q2.push_back(r);
                r.due = cyc + 3;
                q4.push_back(r);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                bit          ev;
                bit          ee;
                logic [31:0] ed;
                ev = 0; ee = 0; ed = '0;
                if (q2.size() > 0 && q2[0].due == cyc) begin
                    ev = 1; ee = q2[0].err; ed = q2[0].rdata;
                    q2.delete(0);
                end
                chk("ready2", 64'(ready2), 64'(!in_init));
                chk("valid2", 64'(valid2), 64'(ev));
                chk("err2",   64'(err2),   64'(ee));
                chk("rdata2", 64'(rdata2), 64'(ed));
                ev = 0; ee = 0; ed = '0;
                if (q4.size() > 0 && q4[0].due == cyc) begin
                    ev = 1; ee = q4[0].err; ed = q4[0].rdata;
                    q4.delete(0);
                end
                chk("ready4", 64'(ready4), 64'(!in_init));
                chk("valid4", 64'(valid4), 64'(ev));
                chk("err4",   64'(err4),   64'(ee));
                chk("rdata4", 64'(rdata4), 64'(ed));
            end
        end
    end

    task automatic put(input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready2 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready2), 64'(0));
        chk("reset_valid", 64'(valid4), 64'(0));
        // requests presented during INIT must be ignored
        req_valid = 1; req_we = 1; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        rst = 0;
        wait_ready(n);
        req_valid = 0;
        chk("init_len", 64'(n), 64'(MEMSIZE));

        put(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        put(1, 0, 32'h10, 32'h0, 4'h0);
        chk("wr_rsp_valid", 64'(valid2), 64'(1));
        chk("wr_rsp_rdata", 64'(rdata2), 64'(0));
        put(0, 0, 32'h0, 32'h0, 4'h0);
        chk("rd_rsp_rdata", 64'(rdata2), 64'(32'hDEAD_BEEF));
        idle(2);
        chk("rd_rsp4_rdata", 64'(rdata4), 64'(32'hDEAD_BEEF));
        idle(2);

        put(1, 1, 32'h20, 32'h1122_3344, 4'hF);
        put(1, 1, 32'h20, 32'hAABB_CCDD, 4'h5);
        put(1, 0, 32'h20, 32'h0, 4'h0);
        idle(1);
        chk("partial_rdata", 64'(rdata2), 64'(32'h11BB_33DD));
        put(1, 1, 32'h20, 32'hFFFF_FFFF, 4'h0);
        put(1, 0, 32'h20, 32'h0, 4'h0);
        idle(1);
        chk("be0_rdata", 64'(rdata2), 64'(32'h11BB_33DD));

        put(1, 0, 32'h2, 32'h0, 4'h0);
        idle(1);
        chk("misalign_err", 64'(err2), 64'(1));
        chk("misalign_rdata", 64'(rdata2), 64'(0));
        put(1, 1, 32'(MEMSIZE * 4), 32'hCAFE_F00D, 4'hF);
        idle(1);
        chk("oor_err", 64'(err2), 64'(1));
        put(1, 1, 32'h11, 32'h0, 4'hF);
        put(1, 0, 32'h0, 32'h0, 4'h0);
        idle(1);
        chk("idx0_rdata", 64'(rdata2), 64'(0));
        chk("idx0_err", 64'(err2), 64'(0));
        put(1, 1, 32'(MEMSIZE * 4 - 4), 32'h1234_5678, 4'hF);
        put(1, 0, 32'(MEMSIZE * 4 - 4), 32'h0, 4'h0);
        put(1, 0, 32'h10, 32'h0, 4'h0);
        chk("last_rdata", 64'(rdata2), 64'(32'h1234_5678));
        idle(6);

        // streamed reads, reset lands in the cycle the 3rd latency-4 response is visible
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin
                chk("third_rsp4", 64'(valid4), 64'(1));
                rst = 1;
            end
            put(1, 0, 32'(4 * i), 32'h0, 4'h0);
        end
        req_valid = 0;
        rst = 0;
        wait_ready(n);
        chk("reinit_len", 64'(n), 64'(MEMSIZE));

        idle(10);
        rst = 1;
        idle(1);
        rst = 0;
        wait_ready(n);
        chk("init_restart_len", 64'(n), 64'(MEMSIZE));

        put(1, 0, 32'h10, 32'h0, 4'h0);
        idle(3);
        chk("post_init_valid", 64'(valid4), 64'(1));
        chk("post_init_rdata", 64'(rdata4), 64'(0));
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_pipe.md
DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 SHALL have parameter BUS, default 32, meaning data and address width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter MEMSIZE, default 4096, meaning depth in BUS-wide words; must be a power of two.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning response latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset sampled on the rising edge of clk.
REQ-006 SHALL have port req_valid, input, 1 bit, meaning a request is presented.
REQ-007 SHALL have port req_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, BUS bits, meaning a byte address.
REQ-010 SHALL have port req_wdata, input, BUS bits, meaning write data.
REQ-011 SHALL have port req_be, input, BUS/8 bits, meaning byte enables for a write, where bit i enables byte lane i.
REQ-012 SHALL have port rsp_valid, output, 1 bit, meaning a one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata, output, BUS bits, meaning read data.
REQ-014 SHALL have port rsp_err, output, 1 bit, meaning the request was rejected.

Function
REQ-015 SHALL implement a two-state FSM: INIT, RUN.
REQ-016 In INIT, SHALL write zero to one word per cycle, starting at index 0 and stepping up to MEMSIZE-1.
REQ-017 In INIT, SHALL hold req_ready=0.
REQ-018 SHALL move from INIT to RUN in the cycle after writing index MEMSIZE-1, so INIT lasts exactly MEMSIZE cycles.
REQ-019 In RUN, SHALL hold req_ready=1; a request is accepted when req_valid & req_ready.
REQ-020 SHALL form the word index as req_addr >> log2(BUS/8).
REQ-021 SHALL treat a request as misaligned when any of the low log2(BUS/8) address bits is nonzero.
REQ-022 SHALL treat a request as out of range when the word index >= MEMSIZE.
REQ-023 For an accepted, legal write, SHALL update only the byte lanes with req_be set, committing at the accept edge.
REQ-024 A write with req_be = 0 SHALL be legal and SHALL leave memory unchanged.
REQ-025 For an accepted, legal read, SHALL sample the memory word at the accept edge.
REQ-026 A read accepted in the cycle after a write to the same word SHALL return the newly written data.
REQ-027 Every accepted request, read or write, SHALL produce exactly one rsp_valid pulse exactly RD_LAT cycles after the accept edge.
REQ-028 Responses SHALL be returned in acceptance order, with back-to-back throughput of one request per cycle.
REQ-029 Each response SHALL have rsp_rdata = memory word for a legal read, and 0 for writes and errored requests.
REQ-030 Each response SHALL have rsp_err = 1 iff the request was misaligned or out of range.
REQ-031 An errored write SHALL modify no memory.
REQ-032 When rsp_valid=0, SHALL hold rsp_rdata=0 and rsp_err=0.
REQ-033 req_valid in INIT SHALL be ignored: no memory change and no response.
REQ-034 The response pipeline SHALL be RD_LAT stages of {valid, err, rdata}; internal index and counter widths SHALL be $clog2(MEMSIZE) bits.

Reset
REQ-035 On rst=1, SHALL enter INIT with the clear counter at 0.
REQ-036 On rst=1, SHALL clear all response-pipeline valid bits.
REQ-037 On rst=1, SHALL drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 in the following cycle.
REQ-038 Reset asserted during RUN SHALL drop all in-flight responses, which are never emitted, and SHALL restart the full memory clear.
REQ-039 Reset asserted during INIT SHALL restart the clear from index 0.

Verification
REQ-040 Reset, then count cycles to first req_ready=1 -> exactly MEMSIZE cycles, with all outputs 0 throughout.
REQ-041 BUS=32, RD_LAT=2: write 0xDEADBEEF to addr 0x10 with be=0xF, then read 0x10 in the next cycle -> write response with rdata=0 and err=0, then read response with rdata 0xDEADBEEF, each 2 cycles after its accept edge.
REQ-042 Partial write: word at 0x20 holds 0x11223344; write 0xAABBCCDD with be=0x5, then read 0x20 -> rdata 0x11BB33DD.
REQ-043 Errors: read at addr 0x2 -> err=1, rdata=0; write to word index MEMSIZE -> err=1, and a subsequent read of index 0 is unchanged.
REQ-044 Stream 8 back-to-back reads with RD_LAT=4, assert rst in the cycle of the 3rd response -> no further rsp_valid, INIT restarts, and post-INIT reads return 0.
REQ-045 Hold req_valid=1 during INIT -> no responses and no memory change.
